sobel_stream: RTL and testbench

Streaming, parametrised Sobel edge detector: the next-generation edge stage between the captured-image BRAM and the edge BRAM. It reads a full RGB frame in raster order at one pixel per clock, keeps two line buffers, and computes |Gx|+|Gy| for every 3×3 window. Each pixel gets exactly one write to the edge BRAM: a binary edge flag, or the scaled magnitude. Frame size, channel width, BRAM latency, border margin and output width are parameters; threshold and mode are runtime inputs.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_stream_if.sv | 32 +++
 rtl/sobel_line_buffer.sv | 40 ++++
 rtl/sobel_stream.sv | 211 +++++++++++++++++++++
 tb/tb_sobel_stream.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel edge stage.
package sobel_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    function automatic int unsigned addr_w(input int unsigned w, input int unsigned h);
        return $clog2(w * h);
    endfunction

    function automatic int unsigned mag_w(input int unsigned ch_w);
        return ch_w + 3;
    endfunction

    // Luma approximation; callers truncate the result to their channel width.
    function automatic logic [15:0] gray16(input logic [15:0] r, input logic [15:0] g,
                                           input logic [15:0] b);
        return (r >> 2) + (g >> 1) + (g >> 3) + (b >> 3);
    endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Control, source-read and edge-write signals of the Sobel stage.
interface sobel_stream_if import sobel_pkg::*; #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned CH_W   = 4,
    parameter int unsigned OUT_W  = 4
) ();
    localparam int unsigned ADDR_W = addr_w(WIDTH, HEIGHT);
    localparam int unsigned MAG_W  = mag_w(CH_W);

    logic              start;
    logic [MAG_W-1:0]  threshold;
    logic              mode;
    logic              busy;
    logic              done;
    logic [3*CH_W-1:0] pixel_data;
    logic [ADDR_W-1:0] pic_memory_addr;
    logic [OUT_W-1:0]  edge_data;
    logic [ADDR_W-1:0] edge_memory_addr;
    logic              edge_we;

    modport master (
        input  start, threshold, mode, pixel_data,
        output busy, done, pic_memory_addr, edge_data, edge_memory_addr, edge_we
    );

    modport slave (
        output start, threshold, mode, pixel_data,
        input  busy, done, pic_memory_addr, edge_data, edge_memory_addr, edge_we
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// Two cascaded one-row delays producing the vertical column {y-1, y, y+1}.
module sobel_line_buffer #(
    parameter int unsigned WIDTH = 640,
    parameter int unsigned CH_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [CH_W-1:0] din,
    output logic [CH_W-1:0] col_top,
    output logic [CH_W-1:0] col_mid,
    output logic [CH_W-1:0] col_bot
);
    localparam int unsigned PTR_W = $clog2(WIDTH);

    logic [CH_W-1:0]  row1 [WIDTH];
    logic [CH_W-1:0]  row2 [WIDTH];
    logic [PTR_W-1:0] ptr;

    assign col_bot = din;
    assign col_mid = row1[ptr];
    assign col_top = row2[ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(WIDTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: every slot is rewritten before it is read in a frame.
    always_ff @(posedge clk) begin
        if (en) begin
            row1[ptr] <= din;
            row2[ptr] <= row1[ptr];
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel |Gx|+|Gy| stage: raster reads in, one edge write per pixel out.
module sobel_stream import sobel_pkg::*; #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned CH_W   = 4,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned MARGIN = 1,
    parameter int unsigned OUT_W  = 4
) (
    input logic            clk,
    input logic            reset,
    sobel_stream_if.master bus
);
    localparam int unsigned ADDR_W = addr_w(WIDTH, HEIGHT);
    localparam int unsigned MAG_W  = mag_w(CH_W);
    localparam int unsigned GR_W   = CH_W + 3;
    localparam int unsigned NPIX   = WIDTH * HEIGHT;
    localparam int unsigned XW     = $clog2(WIDTH);
    localparam int unsigned YW     = $clog2(HEIGHT);
    localparam int unsigned CNT_W  = $clog2(WIDTH + 2);
    localparam int unsigned SHIFT  = (OUT_W < MAG_W) ? MAG_W - OUT_W : 0;

    state_t state, state_nxt;
    logic   go, last_rd, last_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        last_rd   = (bus.pic_memory_addr == ADDR_W'(NPIX - 1));
        last_wr   = bus.edge_we && (bus.edge_memory_addr == ADDR_W'(NPIX - 1));
        case (state)
            IDLE, DONE: if (bus.start) begin
                go        = 1'b1;
                state_nxt = RUN;
            end
            RUN:     if (last_rd) state_nxt = FLUSH;
            FLUSH:   if (last_wr) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    logic [MAG_W-1:0] thr_q;
    logic             mode_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.pic_memory_addr <= '0;
            thr_q               <= '0;
            mode_q              <= 1'b0;
        end else begin
            bus.busy <= (state_nxt == RUN) || (state_nxt == FLUSH);
            bus.done <= (state_nxt == DONE);
            if (go) begin
                bus.pic_memory_addr <= '0;
                thr_q               <= bus.threshold;
                mode_q              <= bus.mode;
            end else if (state == RUN && !last_rd) begin
                bus.pic_memory_addr <= bus.pic_memory_addr + ADDR_W'(1);
            end
        end
    end

    // Read-valid delay line matching the source BRAM latency.
    logic [RD_LAT-1:0] vld_sr;
    logic              in_valid;

    assign in_valid = vld_sr[RD_LAT-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_sr <= '0;
        else       vld_sr <= RD_LAT'({vld_sr, state == RUN});
    end

    // Centre tracking starts once the window's bottom-right pixel (W+1) arrives.
    logic [CNT_W-1:0]  in_cnt;
    logic              cen_run, cen_last;
    logic [ADDR_W-1:0] cen_idx;
    logic [XW-1:0]     cx;
    logic [YW-1:0]     cy;

    assign cen_last = (cen_idx == ADDR_W'(NPIX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt  <= '0;
            cen_run <= 1'b0;
            cen_idx <= '0;
            cx      <= '0;
            cy      <= '0;
        end else if (go) begin
            in_cnt  <= '0;
            cen_run <= 1'b0;
            cen_idx <= '0;
            cx      <= '0;
            cy      <= '0;
        end else begin
            if (in_valid && in_cnt != CNT_W'(WIDTH + 1)) in_cnt <= in_cnt + CNT_W'(1);
            if (in_valid && in_cnt == CNT_W'(WIDTH))     cen_run <= 1'b1;
            else if (cen_run && cen_last)                cen_run <= 1'b0;
            if (cen_run && !cen_last) begin
                cen_idx <= cen_idx + ADDR_W'(1);
                if (cx == XW'(WIDTH - 1)) begin
                    cx <= '0;
                    cy <= cy + YW'(1);
                end else begin
                    cx <= cx + XW'(1);
                end
            end
        end
    end

    logic [CH_W-1:0] gray_in, col_top, col_mid, col_bot;

    assign gray_in = CH_W'(gray16(16'(bus.pixel_data[3*CH_W-1 -: CH_W]),
                                  16'(bus.pixel_data[2*CH_W-1 -: CH_W]),
                                  16'(bus.pixel_data[CH_W-1:0])));

    sobel_line_buffer #(.WIDTH(WIDTH), .CH_W(CH_W)) u_lb (
        .clk     (clk),
        .reset   (reset),
        .en      (in_valid),
        .din     (gray_in),
        .col_top (col_top),
        .col_mid (col_mid),
        .col_bot (col_bot)
    );

    // Left and middle window columns; the right column is the live line-buffer output.
    logic [CH_W-1:0] wl [3];
    logic [CH_W-1:0] wm [3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wl <= '{default: '0};
            wm <= '{default: '0};
        end else if (in_valid) begin
            wl <= wm;
            wm <= '{col_top, col_mid, col_bot};
        end
    end

    function automatic logic signed [GR_W-1:0] sx(input logic [CH_W-1:0] v);
        return signed'(GR_W'(v));
    endfunction

    logic signed [GR_W-1:0] gx, gy;
    logic                   border;

    always_comb begin
        gx = sx(wl[0]) - sx(col_top) + (sx(wl[1]) <<< 1) - (sx(col_mid) <<< 1)
           + sx(wl[2]) - sx(col_bot);
        gy = sx(wl[0]) + (sx(wm[0]) <<< 1) + sx(col_top)
           - sx(wl[2]) - (sx(wm[2]) <<< 1) - sx(col_bot);
        border = (cx < XW'(MARGIN)) || (cx >= XW'(WIDTH - MARGIN)) ||
                 (cy < YW'(MARGIN)) || (cy >= YW'(HEIGHT - MARGIN));
    end

    // Stage 1: gradients, zeroed at the border so out-of-frame samples go no further.
    logic                   s1_valid;
    logic [ADDR_W-1:0]      s1_addr;
    logic signed [GR_W-1:0] s1_gx, s1_gy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_gx    <= '0;
            s1_gy    <= '0;
        end else begin
            s1_valid <= cen_run;
            s1_addr  <= cen_idx;
            s1_gx    <= border ? '0 : gx;
            s1_gy    <= border ? '0 : gy;
        end
    end

    logic [MAG_W-1:0] ax, ay, mag;
    logic [OUT_W-1:0] mag_sc;

    always_comb begin
        ax     = s1_gx[GR_W-1] ? unsigned'(-s1_gx) : unsigned'(s1_gx);
        ay     = s1_gy[GR_W-1] ? unsigned'(-s1_gy) : unsigned'(s1_gy);
        mag    = ax + ay;
        mag_sc = OUT_W'(mag >> SHIFT);
    end

    // Stage 2: threshold or scale, then the edge BRAM write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.edge_we          <= 1'b0;
            bus.edge_memory_addr <= '0;
            bus.edge_data        <= '0;
        end else begin
            bus.edge_we <= s1_valid;
            if (s1_valid) begin
                bus.edge_memory_addr <= s1_addr;
                bus.edge_data        <= mode_q ? mag_sc : {OUT_W{mag > thr_q}};
            end else begin
                bus.edge_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on a 16x8 frame with a 2-cycle source BRAM.
module tb_sobel_stream;
    import sobel_pkg::*;

    localparam int unsigned W   = 16;
    localparam int unsigned H   = 8;
    localparam int unsigned CH  = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned MRG = 1;
    localparam int unsigned OW  = 4;
    localparam int unsigned N   = W * H;
    localparam int unsigned MW  = CH + 3;

    logic clk = 1'b0;
    logic reset;

    sobel_stream_if #(.WIDTH(W), .HEIGHT(H), .CH_W(CH), .OUT_W(OW)) bus ();

    sobel_stream #(.WIDTH(W), .HEIGHT(H), .CH_W(CH), .RD_LAT(LAT), .MARGIN(MRG), .OUT_W(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Source BRAM model with LAT cycles of read latency.
    int unsigned img [N];
    logic [11:0] rd_pipe [LAT];

    always @(posedge clk) begin
        rd_pipe[0] <= 12'(img[bus.pic_memory_addr]);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.pixel_data = rd_pipe[LAT-1];

    int cyc = 0;
    int t_start = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_addr [$];
    int wr_data [$];
    int wr_off  [$];

    always @(negedge clk) begin
        if (bus.edge_we === 1'b1) begin
            wr_addr.push_back(int'(bus.edge_memory_addr));
            wr_data.push_back(int'(bus.edge_data));
            wr_off.push_back(cyc - t_start);
        end
    end

    int checks = 0;
    int errors = 0;
    int exp_img [N];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int gray(input int unsigned p);
        int r, g, b;
        r = int'((p >> 8) & 15);
        g = int'((p >> 4) & 15);
        b = int'(p & 15);
        return ((r >> 2) + (g >> 1) + (g >> 3) + (b >> 3)) & 15;
    endfunction

    // Reference edge image straight from the Sobel definition.
    function automatic void model(input int thr, input bit md);
        int p [3][3];
        int gx, gy, mag;
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                if (x < int'(MRG) || x >= int'(W - MRG) || y < int'(MRG) || y >= int'(H - MRG)) begin
                    exp_img[y*W + x] = 0;
                end else begin
                    for (int dy = 0; dy < 3; dy++)
                        for (int dx = 0; dx < 3; dx++)
                            p[dy][dx] = gray(img[(y + dy - 1) * int'(W) + x + dx - 1]);
                    gx = p[0][0] - p[0][2] + 2*p[1][0] - 2*p[1][2] + p[2][0] - p[2][2];
                    gy = p[0][0] + 2*p[0][1] + p[0][2] - p[2][0] - 2*p[2][1] - p[2][2];
                    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                    if (md) exp_img[y*W + x] = mag >> (MW - OW);
                    else    exp_img[y*W + x] = (mag > thr) ? (1 << OW) - 1 : 0;
                end
            end
        end
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_off.delete();
    endtask

    task automatic run_frame(input int thr, input bit md, input bit poke);
        int done_off;
        clear_log();
        model(thr, md);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.threshold = MW'(thr);
        bus.mode      = md;
        @(posedge clk);
        #1;
        t_start       = cyc;
        bus.start     = 1'b0;
        bus.threshold = MW'($urandom);
        bus.mode      = 1'($urandom);
        done_off      = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (n == 0) begin
                check("busy_on_entry", bus.busy, 1);
                check("done_on_entry", bus.done, 0);
            end
            if (n < int'(N)) check($sformatf("rd_addr[%0d]", n), bus.pic_memory_addr, n);
            if (poke) bus.start = (n == 10 || n == int'(N) + 5);
            if (bus.done) begin
                done_off = n;
                break;
            end
        end
        bus.start = 1'b0;
        check("done_reached", done_off >= 0, 1);
        check("busy_at_done", bus.busy, 0);
        check("wr_count", wr_addr.size(), N);
        for (int i = 0; i < wr_addr.size() && i < int'(N); i++) begin
            check($sformatf("wr_addr[%0d]", i), wr_addr[i], i);
            check($sformatf("wr_data[%0d]", i), wr_data[i], exp_img[i]);
            check($sformatf("wr_cycle[%0d]", i), wr_off[i], int'(W + LAT + 3) + i);
        end
        if (wr_off.size() > 0) check("done_after_last_wr", done_off, wr_off[wr_off.size()-1] + 1);
    endtask

    initial begin
        int seen;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.threshold = '0;
        bus.mode      = 1'b0;
        for (int i = 0; i < int'(N); i++) img[i] = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_we", bus.edge_we, 0);
        check("rst_edge_data", bus.edge_data, 0);
        check("rst_edge_addr", bus.edge_memory_addr, 0);
        check("rst_pic_addr", bus.pic_memory_addr, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Flat frame: no gradients anywhere.
        for (int i = 0; i < int'(N); i++) img[i] = 32'h7A3;
        run_frame(0, 1'b0, 1'b0);

        // Vertical step between columns 7 and 8.
        for (int i = 0; i < int'(N); i++) img[i] = ((i % W) < 8) ? 32'h000 : 32'hFFF;
        run_frame(47, 1'b0, 1'b0);
        if (wr_data.size() > int'(W + 8)) check("step_bin_x8y1", wr_data[W + 8], 15);
        run_frame(48, 1'b0, 1'b0);
        if (wr_data.size() > int'(W + 8)) check("step_bin48_x8y1", wr_data[W + 8], 0);
        run_frame(0, 1'b1, 1'b0);
        if (wr_data.size() > int'(6*W + 7)) check("step_mag_x7y6", wr_data[6*W + 7], 6);

        // Random frames; the second pokes start in RUN and FLUSH, the next restarts from DONE.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < int'(N); i++) img[i] = $urandom_range(0, 4095);
            run_frame(int'($urandom_range(0, 60)), 1'($urandom), f == 1);
        end

        // Reset in the middle of a frame.
        for (int i = 0; i < int'(N); i++) img[i] = $urandom_range(0, 4095);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        t_start   = cyc;
        bus.start = 1'b0;
        seen      = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus.edge_we && bus.edge_memory_addr == 7'd40) begin
                seen = 1;
                break;
            end
        end
        check("reached_write_40", seen, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_we", bus.edge_we, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        clear_log();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("no_wr_after_reset", wr_addr.size(), 0);
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        run_frame(int'($urandom_range(0, 60)), 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
